// File: rtl/seg_scan_sched.sv
// Scan scheduler for an 8-digit multiplexed 7-segment display.
// Uses a double-buffered frame that loads only at frame boundaries, with dead-time blanking per slot.
module seg_scan_sched #(
    parameter int unsigned CLK_DIV   = 1000,
    parameter int unsigned BLANK_CYC = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_mask,
    input  logic        lzb,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  cat,
    output logic        frame_start
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   sh_dig;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_en;
    logic          sh_lzb;

    logic          boundary;
    logic [3:0]    cur_nib;
    logic [7:0]    visible;
    logic          tail_dark;
    logic [7:0]    cat_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign boundary = (idx == 3'd7) && (cnt == CNT_LAST);
    assign cur_nib  = sh_dig[{idx, 2'b00} +: 4];

    // Walk from the leftmost digit down; a digit is lz-blanked while every
    // position from it up to digit 7 is zero or disabled. Digit 0 never blanks.
    always_comb begin
        visible   = sh_en;
        tail_dark = 1'b1;
        for (int unsigned k = 0; k < 7; k++) begin
            tail_dark = tail_dark & ((sh_dig[4*(7-k) +: 4] == 4'd0) | ~sh_en[7-k]);
            if (sh_lzb && tail_dark)
                visible[7-k] = 1'b0;
        end
    end

    always_comb begin
        cat_d = '1;
        seg_d = '0;
        dp_d  = 1'b0;
        if ((cnt >= CNT_SHOW) && visible[idx]) begin
            cat_d = ~(8'd1 << idx);
            seg_d = seg_decode(cur_nib);
            dp_d  = sh_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            sh_dig      <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
            sh_lzb      <= 1'b0;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
            cat         <= '1;
            seg         <= '0;
            dp          <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            upd_ack <= boundary && upd_req;
            if (boundary && upd_req) begin
                sh_dig <= digits_in;
                sh_dp  <= dp_in;
                sh_en  <= en_mask;
                sh_lzb <= lzb;
            end

            frame_start <= (idx == 3'd0) && (cnt == '0);
            cat         <= cat_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with CLK_DIV=8, BLANK_CYC=2.
// A cycle model pushes expected pin values to a queue; they are popped and compared after each edge.
module tb_seg_scan_sched;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_mask;
    logic        lzb;
    logic        upd_req;
    logic        upd_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  cat;
    logic        frame_start;

    seg_scan_sched #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .en_mask(en_mask), .lzb(lzb), .upd_req(upd_req), .upd_ack(upd_ack),
        .seg(seg), .dp(dp), .cat(cat), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cat;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic auto_drop = 1'b1;

    logic [6:0] seg_tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
                                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    int          m_idx, m_cnt;
    logic [31:0] m_dig;
    logic [7:0]  m_dp, m_en;
    logic        m_lzb;

    logic [7:0]  l_cat;
    logic [6:0]  l_seg;
    logic        l_dp, l_ack, l_fs;

    logic [7:0]  f_cat [64];
    logic [6:0]  f_seg [64];
    logic        f_dp  [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] m_nib(input int i);
        logic [31:0] tmp;
        tmp = m_dig >> (4 * i);
        return tmp[3:0];
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic vis;
        e.cat = 8'hFF; e.seg = 7'd0; e.dp = 1'b0; e.ack = 1'b0; e.fs = 1'b0;
        vis = m_en[m_idx];
        if (m_lzb && m_idx != 0) begin
            logic dark;
            dark = 1'b1;
            for (int j = m_idx; j < 8; j++)
                if (m_nib(j) != 4'd0 && m_en[j]) dark = 1'b0;
            if (dark) vis = 1'b0;
        end
        if (m_cnt >= 2 && vis) begin
            e.cat = 8'hFF;
            e.cat[m_idx] = 1'b0;
            e.seg = seg_tbl[m_nib(m_idx)];
            e.dp  = m_dp[m_idx];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_dig = '0; m_dp = '0; m_en = '0; m_lzb = 1'b0;
        q.delete();
    endtask

    task automatic step();
        exp_t e;
        logic do_load;
        e = model_out();
        do_load = (m_idx == 7) && (m_cnt == 7) && upd_req;
        e.ack = do_load;
        e.fs  = (m_idx == 0) && (m_cnt == 0);
        q.push_back(e);
        @(posedge clk);
        if (do_load) begin
            m_dig = digits_in; m_dp = dp_in; m_en = en_mask; m_lzb = lzb;
        end
        if (m_cnt == 7) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 8;
        end else begin
            m_cnt++;
        end
        cyc++;
        #1;
        l_cat = cat; l_seg = seg; l_dp = dp; l_ack = upd_ack; l_fs = frame_start;
        e = q.pop_front();
        chk("cat", {24'd0, l_cat}, {24'd0, e.cat});
        chk("seg", {25'd0, l_seg}, {25'd0, e.seg});
        chk("dp", {31'd0, l_dp}, {31'd0, e.dp});
        chk("upd_ack", {31'd0, l_ack}, {31'd0, e.ack});
        chk("frame_start", {31'd0, l_fs}, {31'd0, e.fs});
        if (l_ack && auto_drop) upd_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_ack();
        int n;
        n = 0;
        do begin step(); n++; end while (!l_ack && n < 200);
        chk("ack_timeout", {31'd0, l_ack}, 32'd1);
    endtask

    task automatic run_to_fs();
        int n;
        n = 0;
        do begin step(); n++; end while (!l_fs && n < 200);
        chk("fs_timeout", {31'd0, l_fs}, 32'd1);
    endtask

    // f_* index t = pin cycle within frame: slot t/8, phase t%8.
    task automatic capture();
        run_to_fs();
        f_cat[0] = l_cat; f_seg[0] = l_seg; f_dp[0] = l_dp;
        for (int t = 1; t < 64; t++) begin
            step();
            f_cat[t] = l_cat; f_seg[t] = l_seg; f_dp[t] = l_dp;
        end
    endtask

    task automatic chk_slot(input int k, input logic [7:0] c, input logic [6:0] s);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("slot%0d_cat", k), {24'd0, f_cat[8*k+t]}, {24'd0, (t < 2) ? 8'hFF : c});
            chk($sformatf("slot%0d_seg", k), {25'd0, f_seg[8*k+t]}, {25'd0, (t < 2) ? 7'd0 : s});
        end
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e, input logic z);
        digits_in = d; dp_in = p; en_mask = e; lzb = z;
        auto_drop = 1'b1;
        upd_req   = 1'b1;
        run_to_ack();
        capture();
    endtask

    task automatic check_dark_frames(input string tag, input int n);
        int fs_cnt, first_fs, acks;
        fs_cnt = 0; first_fs = -1; acks = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (l_fs) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
            end
            if (l_ack) acks++;
        end
        chk({tag, "_first_fs"}, first_fs, 1);
        chk({tag, "_fs_count"}, fs_cnt, 3);
        chk({tag, "_acks"}, acks, 0);
    endtask

    initial begin
        int ack_cnt, ack_at0, ack_at1;
        rst_n = 1'b0; digits_in = '0; dp_in = '0; en_mask = '0; lzb = 1'b0; upd_req = 1'b0;
        model_reset();

        // 1: reset held, then free-running with empty shadow
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_cat", {24'd0, cat}, 32'hFF);
            chk("rst_seg", {25'd0, seg}, 32'd0);
            chk("rst_ack_fs", {30'd0, upd_ack, frame_start}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_dark_frames("t1", 130);

        // 2: load 0x19, all enabled, no blanking
        load(32'h00000019, 8'h00, 8'hFF, 1'b0);
        chk_slot(0, 8'hFE, 7'b1101111);
        chk_slot(1, 8'hFD, 7'b0000110);
        for (int k = 2; k < 8; k++) chk_slot(k, ~(8'd1 << k), 7'b0111111);

        // 3: leading-zero blanking, then all-zero value
        load(32'h00000019, 8'h00, 8'hFF, 1'b1);
        chk_slot(0, 8'hFE, 7'b1101111);
        chk_slot(1, 8'hFD, 7'b0000110);
        for (int k = 2; k < 8; k++) chk_slot(k, 8'hFF, 7'd0);
        load(32'h00000000, 8'h00, 8'hFF, 1'b1);
        chk_slot(0, 8'hFE, 7'b0111111);
        for (int k = 1; k < 8; k++) chk_slot(k, 8'hFF, 7'd0);

        // 4: mid-frame request held for two frames
        run_to_fs();
        run(20);
        digits_in = 32'h12345678; lzb = 1'b0;
        auto_drop = 1'b0;
        upd_req   = 1'b1;
        ack_cnt = 0; ack_at0 = -1; ack_at1 = -1;
        for (int i = 0; i < 140; i++) begin
            step();
            if (l_ack) begin
                if (ack_cnt == 0) ack_at0 = i;
                if (ack_cnt == 1) ack_at1 = i;
                ack_cnt++;
            end
        end
        upd_req = 1'b0;
        chk("t4_ack_count", ack_cnt, 2);
        chk("t4_ack_spacing", ack_at1 - ack_at0, 64);
        chk("t4_first_ack_pos", ack_at0, 42);
        capture();
        chk_slot(0, 8'hFE, 7'b1111111);
        chk_slot(3, 8'hF7, 7'b1101101);
        chk_slot(7, 8'h7F, 7'b0000110);

        // 5: nibble A, disabled then enabled; decimal point on digit 1
        load(32'h0000A000, 8'h00, 8'hF7, 1'b0);
        chk_slot(3, 8'hFF, 7'd0);
        chk_slot(4, 8'hEF, 7'b0111111);
        load(32'h0000A000, 8'h00, 8'hFF, 1'b0);
        chk_slot(3, 8'hF7, 7'd0);
        load(32'h0000A000, 8'h02, 8'hFF, 1'b0);
        for (int t = 0; t < 64; t++)
            chk("t5_dp", {31'd0, f_dp[t]}, {31'd0, (t / 8 == 1) && (t % 8 >= 2)});

        // 6: asynchronous reset in the slot-4 show phase
        run_to_fs();
        run(35);
        chk("t6_pre_cat", {24'd0, l_cat}, 32'hEF);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_cat", {24'd0, cat}, 32'hFF);
        chk("t6_async_seg", {25'd0, seg}, 32'd0);
        chk("t6_async_dp", {31'd0, dp}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_dark_frames("t6", 130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
- Time-multiplexed scan scheduler that shares the board's single 7-segment bus (seg/dp) among 8 digit positions (cat).
- Holds a double-buffered frame of 8 BCD digits, decimal points and enable bits.
- Steps through one digit slot per CLK_DIV clocks, inserts a dead-time blank at the start of each slot to suppress ghosting, and optionally blanks leading zeros.
- New digit data from counters or other producers is accepted only at frame boundaries through a req/ack handshake, so a frame never shows torn data.

Parameters:
CLK_DIV, 1000, clocks per digit slot; must be ≥2.
BLANK_CYC, 50, dead-time clocks at the start of each slot; must be < CLK_DIV.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits_in  in  32  8 BCD nibbles; [3:0]=digit 0 (rightmost, cat[0]) ... [31:28]=digit 7
dp_in  in  8  decimal point per digit, active-high
en_mask  in  8  digit enable, active-high
lzb  in  1  leading-zero blanking enable
upd_req  in  1  producer requests load of digits_in/dp_in/en_mask/lzb
upd_ack  out  1  one-cycle pulse: inputs captured into shadow
seg  out  7  segments, active-high, bit0=a .. bit6=g
dp  out  1  decimal point, active-high
cat  out  8  digit select, active-low, at most one bit low
frame_start  out  1  one-cycle pulse at the start of each slot-0 window

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: cat=8'hFF, seg=0, dp=0, upd_ack=0, frame_start=0.
  - Internal state: slot counter cnt=0, slot index idx=0, shadow digits=0, shadow dp=0, shadow en=0, shadow lzb=0.
  - Any pending request is dropped.
- Sequencing:
  - cnt counts 0..CLK_DIV-1.
  - At cnt=CLK_DIV-1, cnt wraps to 0 and idx advances by 1, wrapping 7→0.
  - Frame = 8 slots = 8*CLK_DIV clocks.
  - The first frame after reset starts at idx=0, cnt=0.
- Per-slot phases, decoded from (idx, cnt):
  - BLANK (cnt<BLANK_CYC): cat=FF, seg=0, dp=0.
  - SHOW (cnt≥BLANK_CYC):
    - If the digit is visible: cat=~(1<<idx), seg=decode(shadow nibble idx), dp=shadow dp[idx].
    - If the digit is not visible: cat=FF, seg=0, dp=0.
- All outputs are registered. The output for internal state (idx, cnt) appears one clock later. Slot timing seen at the pins is therefore exactly BLANK_CYC blank cycles followed by CLK_DIV-BLANK_CYC show cycles.
- Visibility: digit i is visible iff en[i]=1 and not lz-blanked.
- Leading-zero blanking: with shadow lzb=1, digit i (i≥1) is lz-blanked iff every position j in i..7 has nibble 0 or en[j]=0. Digit 0 is never lz-blanked.
- Decode (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10–15 → 0000000, with cat still asserted if the digit is visible.
- Update handshake:
  - Producer raises upd_req and holds it, with inputs stable, until upd_ack.
  - Boundary cycle = idx=7 and cnt=CLK_DIV-1. If upd_req=1 in that cycle, the shadow loads all inputs and upd_ack=1 in the following cycle, which is the first cycle of the new frame.
  - The new data is first visible in slot 0 of that frame.
  - Producer deasserts upd_req on the cycle after ack. If upd_req is still 1 at the next boundary, the block loads again and pulses ack again.
  - upd_req asserted or dropped mid-frame has no effect until a boundary.
  - upd_ack is never high for 2 consecutive cycles.
- frame_start: registered pulse coincident with the first pin-visible cycle of each slot 0, including the first slot 0 after reset release. Asserted once per frame.
- Widths: idx 3 bits; cnt $clog2(CLK_DIV) bits. No arithmetic overflow is possible beyond the defined wraps.
- Reset mid-slot: cat goes to FF immediately (asynchronously). After release, scanning restarts from slot 0, cnt=0, with an all-zero shadow, so the display stays dark until the first load.

Test Plan:
1. CLK_DIV=8, BLANK_CYC=2, hold reset 5 cycles then release, no req → cat=FF, seg=0 throughout; frame_start pulses every 64 cycles, the first pulse in the first cycle after release; upd_ack stays 0.
2. Load digits_in=32'h00000019, en_mask=FF, lzb=0, dp_in=0 → per slot 2 blank + 6 show cycles:
   - slot 0: cat=FE, seg=1101111
   - slot 1: cat=FD, seg=0000110
   - slots 2–7: seg=0111111 with cat=FB..7F
3. Same data with lzb=1 → slots 2–7 keep cat=FF. Then load digits_in=0 → slot 0 shows cat=FE, seg=0111111; all other slots dark.
4. Raise upd_req at cycle 20 of a frame with digits_in=32'h12345678 → display unchanged until the boundary; upd_ack is exactly one pulse, in the cycle after idx=7, cnt=7; new values appear from the next slot 0. Holding upd_req high for 2 frames → 2 separate ack pulses, 64 cycles apart.
5. Nibble 3 = 4'hA, en_mask=8'hF7 → during slot 3, cat=FF (disabled). Then en_mask=FF → cat=F7, seg=0000000. dp_in=8'h02 → dp=1 only during slot 1 show cycles.
6. Assert rst_n=0 mid-slot 4 show phase → cat=FF and seg=0 within the same cycle, with no clock edge needed. After release, slot 0 restarts with a blank phase and the shadow is cleared.
